pipe_ctrl: RTL

- Hazard and flush sequencer for the pipelined core.
- Generates the `stop` input of pc_manager.
- Consumes pc_manager's `breakPipe` and sequences hold/flush of the IF/ID, ID/EX and EX/MEM pipeline registers for taken branches/jumps, load-use hazards, memory wait and halt.
- Also keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Hazard and flush sequencer for the pipelined core: drives pc_manager's stop and
// the hold/flush controls of IF/ID, ID/EX and EX/MEM, plus saturating debug counters.
module pipe_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             break_pipe,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_stop,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_DEPTH - 1);

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_stop     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    pc_stop     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = HALT;
                end else if (break_pipe) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = RELOAD;
                    end
                end else if (mem_busy) begin
                    pc_stop     = 1'b1;
                    if_id_hold  = 1'b1;
                    ex_mem_hold = 1'b1;
                    stall_inc   = 1'b1;
                    state_d     = MEMWAIT;
                end else if (load_use) begin
                    pc_stop     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            FLUSH: begin
                // IF/ID keeps being flushed even while memory stalls the back end
                if_id_flush = 1'b1;
                if (halt_req) begin
                    pc_stop     = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = HALT;
                end else if (break_pipe) begin
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                    fcnt_d      = RELOAD;
                end else if (mem_busy) begin
                    pc_stop     = 1'b1;
                    ex_mem_hold = 1'b1;
                    stall_inc   = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                    if (fcnt_q == 4'd1) state_d = RUN;
                end
            end
            MEMWAIT: begin
                if (halt_req) begin
                    pc_stop     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = HALT;
                end else if (mem_busy) begin
                    pc_stop     = 1'b1;
                    if_id_hold  = 1'b1;
                    ex_mem_hold = 1'b1;
                    stall_inc   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                halted      = 1'b1;
                pc_stop     = 1'b1;
                if_id_hold  = 1'b1;
                ex_mem_hold = 1'b1;
                if (resume && !halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Reset overrides everything so the pipeline fills with NOPs
        if (!rst_n) begin
            state_d     = RUN;
            fcnt_d      = 4'd0;
            pc_stop     = 1'b1;
            if_id_hold  = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_hold = 1'b0;
            halted      = 1'b0;
            stall_inc   = 1'b0;
            flush_inc   = 1'b0;
        end

        stall_cnt_d = stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_inc ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
